// File: rtl/mem_access_ctrl_if.sv
// Signal bundle between mem_access_ctrl and its surroundings.
// The bundle covers the datapath request/store/load handshakes and the single-port memory bus.
interface mem_access_ctrl_if #(
  parameter int LEN_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [7:0]       req_addr;
  logic [LEN_W-1:0] req_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_data;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             busy;
  logic             enable_write;
  logic             enable_read;
  logic [7:0]       ram_addr;
  logic [7:0]       write_data;
  logic [7:0]       read_data;

  // Datapath plus memory, seen from outside the controller.
  modport master (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, read_data,
    input  req_ready, wr_ready, rd_valid, rd_data, busy,
           enable_write, enable_read, ram_addr, write_data
  );

  // The controller itself.
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, read_data,
    output req_ready, wr_ready, rd_valid, rd_data, busy,
           enable_write, enable_read, ram_addr, write_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer for an 8-bit level-sensitive single-port memory:
// single/burst loads and stores with explicit setup, strobe and hold cycles.
module mem_access_ctrl #(
  parameter int RD_LAT = 1,  // read strobe cycles before sampling, 1..4
  parameter int LEN_W  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_SETUP, WR_STROBE, WR_HOLD, RD_SETUP, RD_STROBE
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t           state, state_n;
  logic [7:0]       addr;
  logic [LEN_W-1:0] beats_left;
  logic [1:0]       lat_cnt;
  logic             last_beat;
  logic             rd_last;

  assign last_beat = (beats_left == '0);
  assign rd_last   = (state == RD_STROBE) && (lat_cnt == '0);

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // NOTE: state_n is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (bus.req_valid) state_n = bus.req_write ? WR_DATA : RD_SETUP;
      WR_DATA:   if (bus.wr_valid)  state_n = WR_SETUP;
      WR_SETUP:  state_n = WR_STROBE;
      WR_STROBE: state_n = WR_HOLD;
      WR_HOLD:   state_n = last_beat ? IDLE : WR_DATA;
      RD_SETUP:  state_n = RD_STROBE;
      RD_STROBE: if (lat_cnt == '0) state_n = last_beat ? IDLE : RD_SETUP;
      default:   state_n = IDLE;
    endcase
  end

  // Strobes and wr_ready are registered from the next state, so they line up
  // exactly with the state they belong to without any combinational output path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr             <= '0;
      beats_left       <= '0;
      lat_cnt          <= '0;
      bus.enable_write <= 1'b0;
      bus.enable_read  <= 1'b0;
      bus.wr_ready     <= 1'b0;
      bus.rd_valid     <= 1'b0;
      bus.ram_addr     <= '0;
      bus.write_data   <= '0;
      bus.rd_data      <= '0;
    end else begin
      bus.enable_write <= (state_n == WR_STROBE);
      bus.enable_read  <= (state_n == RD_STROBE);
      bus.wr_ready     <= (state_n == WR_DATA);
      bus.rd_valid     <= rd_last;

      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr       <= bus.req_addr;
            beats_left <= bus.req_len;
            if (!bus.req_write) bus.ram_addr <= bus.req_addr;
          end
        end
        WR_DATA: begin
          if (bus.wr_valid) begin
            bus.write_data <= bus.wr_data;
            bus.ram_addr   <= addr;
          end
        end
        WR_HOLD: begin
          // ram_addr keeps the old beat's address until the next data beat arrives.
          addr <= addr + 8'd1;
          if (!last_beat) beats_left <= beats_left - LEN_W'(1);
        end
        RD_SETUP: lat_cnt <= LAT_INIT;
        RD_STROBE: begin
          if (lat_cnt == '0) begin
            bus.rd_data <= bus.read_data;
            addr        <= addr + 8'd1;
            if (!last_beat) begin
              beats_left   <= beats_left - LEN_W'(1);
              bus.ram_addr <= addr + 8'd1;
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl: one RD_LAT=1 instance for the
// store/load scenarios, one RD_LAT=3 instance for read-latency timing.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.LEN_W(4)) bus1 ();
  mem_access_ctrl_if #(.LEN_W(4)) bus3 ();

  mem_access_ctrl #(.RD_LAT(1), .LEN_W(4)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  mem_access_ctrl #(.RD_LAT(3), .LEN_W(4)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  // Behavioural memories: combinational read, write while the strobe is high.
  logic [7:0] mem1 [256] = '{default: 8'h00};
  logic [7:0] mem3 [256] = '{default: 8'h00};
  assign bus1.read_data = mem1[bus1.ram_addr];
  assign bus3.read_data = mem3[bus3.ram_addr];
  always @(posedge clk) if (bus1.enable_write) mem1[bus1.ram_addr] <= bus1.write_data;

  logic [15:0] wr_exp[$];  // {addr, data} of each expected write strobe
  logic [7:0]  rd_exp[$];  // data of each expected rd_valid beat
  int          ew_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and strobe invariants for the RD_LAT=1 instance.
  logic       ew_prev = 1'b0;
  logic [7:0] prev_addr = 8'h00, prev_wd = 8'h00;
  always @(negedge clk) begin
    if (!reset_n) begin
      ew_prev = 1'b0;
    end else begin
      if (bus1.enable_write || bus1.enable_read)
        check("strobe_excl", 32'(bus1.enable_write & bus1.enable_read), 32'd0);
      if (bus1.enable_write || ew_prev) begin
        check("addr_stable", 32'(bus1.ram_addr), 32'(prev_addr));
        check("data_stable", 32'(bus1.write_data), 32'(prev_wd));
      end
      if (bus1.enable_write) begin
        ew_count++;
        if (wr_exp.size() == 0) check("wr_pending", 32'd0, 32'd1);
        else begin
          logic [15:0] e;
          e = wr_exp.pop_front();
          check("wr_addr", 32'(bus1.ram_addr), 32'(e[15:8]));
          check("wr_data", 32'(bus1.write_data), 32'(e[7:0]));
        end
      end
      if (bus1.rd_valid) begin
        if (rd_exp.size() == 0) check("rd_pending", 32'd0, 32'd1);
        else check("rd_data", 32'(bus1.rd_data), 32'(rd_exp.pop_front()));
      end
      ew_prev = bus1.enable_write;
    end
    prev_addr = bus1.ram_addr;
    prev_wd   = bus1.write_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [7:0] a, input logic [3:0] len);
    logic ok, got;
    ok = 1'b0;
    bus1.req_valid = 1'b1;
    bus1.req_write = w;
    bus1.req_addr  = a;
    bus1.req_len   = len;
    for (int i = 0; i < 50; i++) begin
      got = bus1.req_ready;
      tick();
      if (got) begin ok = 1'b1; break; end
    end
    bus1.req_valid = 1'b0;
    check("req_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] d);
    logic ok, got;
    ok = 1'b0;
    wr_exp.push_back({a, d});
    bus1.wr_valid = 1'b1;
    bus1.wr_data  = d;
    for (int i = 0; i < 50; i++) begin
      got = bus1.wr_ready;
      tick();
      if (got) begin ok = 1'b1; break; end
    end
    bus1.wr_valid = 1'b0;
    check("wr_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus1.req_ready) begin ok = 1'b1; break; end
      tick();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [7:0] wrap_d [4];
    logic [7:0] a;
    int er_total, er_run, er_max, er_runs, pulses, p0, p1;
    logic [7:0] d0, d1;
    logic ok;

    wrap_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset_n = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_len = '0;
    bus1.wr_valid  = 1'b0; bus1.wr_data   = '0;
    bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = '0; bus3.req_len = '0;
    bus3.wr_valid  = 1'b0; bus3.wr_data   = '0;

    // Reset state
    repeat (3) tick();
    check("rst_req_ready", 32'(bus1.req_ready), 32'd1);
    check("rst_busy", 32'(bus1.busy), 32'd0);
    check("rst_strobes", 32'({bus1.enable_write, bus1.enable_read}), 32'd0);
    check("rst_handshake", 32'({bus1.wr_ready, bus1.rd_valid}), 32'd0);
    check("rst_buses", 32'({bus1.ram_addr, bus1.write_data, bus1.rd_data}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single store 0x10 <= 0xA5
    do_req(1'b1, 8'h10, 4'd0);
    send_beat(8'h10, 8'hA5);
    check("st_busy_setup", 32'(bus1.busy), 32'd1);
    tick();
    check("st_strobe", 32'(bus1.enable_write), 32'd1);
    tick();
    check("st_hold", 32'({bus1.busy, bus1.enable_write}), 32'b10);
    tick();
    check("st_busy_fall", 32'({bus1.busy, bus1.req_ready}), 32'b01);
    check("st_pulse_count", 32'(ew_count), 32'd1);
    check("st_mem", 32'(mem1[8'h10]), 32'hA5);

    // Single load from 0x10
    rd_exp.push_back(8'hA5);
    do_req(1'b0, 8'h10, 4'd0);
    check("ld_setup", 32'({bus1.enable_read, bus1.ram_addr}), 32'h010);
    tick();
    check("ld_strobe", 32'({bus1.enable_read, bus1.rd_valid}), 32'b10);
    tick();
    check("ld_valid", 32'({bus1.rd_valid, bus1.enable_read, bus1.req_ready}), 32'b101);
    check("ld_rd_data", 32'(bus1.rd_data), 32'hA5);
    tick();
    check("ld_pulse_end", 32'(bus1.rd_valid), 32'd0);
    check("ld_scoreboard", 32'(rd_exp.size()), 32'd0);

    // Wrap burst store 0xFE..0x01, then load it back
    do_req(1'b1, 8'hFE, 4'd3);
    for (int i = 0; i < 4; i++) begin
      a = 8'hFE + 8'(i);
      send_beat(a, wrap_d[i]);
    end
    wait_idle("wrap_st_done");
    tick();
    check("wrap_mem00", 32'(mem1[8'h00]), 32'h33);
    check("wrap_wr_sb", 32'(wr_exp.size()), 32'd0);
    for (int i = 0; i < 4; i++) rd_exp.push_back(wrap_d[i]);
    do_req(1'b0, 8'hFE, 4'd3);
    wait_idle("wrap_ld_done");
    tick();
    check("wrap_rd_sb", 32'(rd_exp.size()), 32'd0);

    // Write stall mid-burst
    do_req(1'b1, 8'h40, 4'd2);
    send_beat(8'h40, 8'h01);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus1.wr_ready) begin ok = 1'b1; break; end
      tick();
    end
    check("stall_ready", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_quiet", 32'({bus1.enable_write, bus1.ram_addr, bus1.wr_ready}), 32'({1'b0, 8'h40, 1'b1}));
      tick();
    end
    send_beat(8'h41, 8'h02);
    send_beat(8'h42, 8'h03);
    wait_idle("stall_done");
    rd_exp.push_back(8'h01); rd_exp.push_back(8'h02); rd_exp.push_back(8'h03);
    do_req(1'b0, 8'h40, 4'd2);
    wait_idle("stall_ld_done");
    tick();
    check("stall_rd_sb", 32'(rd_exp.size()), 32'd0);

    // RD_LAT=3 two-beat load
    mem3[8'h20] = 8'h5A;
    mem3[8'h21] = 8'hC3;
    check("lat3_ready", 32'(bus3.req_ready), 32'd1);
    bus3.req_valid = 1'b1; bus3.req_write = 1'b0; bus3.req_addr = 8'h20; bus3.req_len = 4'd1;
    tick();
    bus3.req_valid = 1'b0;
    er_total = 0; er_run = 0; er_max = 0; er_runs = 0; pulses = 0; p0 = 0; p1 = 0; d0 = '0; d1 = '0;
    for (int i = 0; i < 14; i++) begin
      if (bus3.enable_read) begin
        er_total++;
        if (er_run == 0) er_runs++;
        er_run++;
        if (er_run > er_max) er_max = er_run;
      end else er_run = 0;
      if (bus3.rd_valid) begin
        if (pulses == 0) begin p0 = i; d0 = bus3.rd_data; end
        else             begin p1 = i; d1 = bus3.rd_data; end
        pulses++;
      end
      tick();
    end
    check("lat3_er_total", 32'(er_total), 32'd6);
    check("lat3_er_runs", 32'(er_runs), 32'd2);
    check("lat3_er_run_len", 32'(er_max), 32'd3);
    check("lat3_pulses", 32'(pulses), 32'd2);
    check("lat3_first_pulse", 32'(p0), 32'd4);
    check("lat3_spacing", 32'(p1 - p0), 32'd4);
    check("lat3_data0", 32'(d0), 32'h5A);
    check("lat3_data1", 32'(d1), 32'hC3);
    check("lat3_idle", 32'(bus3.req_ready), 32'd1);

    // Reset during the strobe of beat 2 of 4
    do_req(1'b1, 8'h80, 4'd3);
    send_beat(8'h80, 8'hAA);
    send_beat(8'h81, 8'hBB);
    tick();
    check("rst_mid_strobe", 32'(bus1.enable_write), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_strobes", 32'({bus1.enable_write, bus1.enable_read}), 32'd0);
    check("rst_mid_state", 32'({bus1.req_ready, bus1.busy, bus1.wr_ready}), 32'b100);
    check("rst_mid_buses", 32'({bus1.ram_addr, bus1.write_data}), 32'd0);
    wr_exp.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("rst_no_write", 32'({bus1.enable_write, bus1.busy}), 32'd0);
      tick();
    end
    check("rst_mem80", 32'(mem1[8'h80]), 32'hAA);
    check("rst_mem81", 32'(mem1[8'h81]), 32'h00);
    do_req(1'b1, 8'h90, 4'd0);
    send_beat(8'h90, 8'h77);
    wait_idle("post_rst_st");
    rd_exp.push_back(8'h77);
    do_req(1'b0, 8'h90, 4'd0);
    wait_idle("post_rst_ld");
    tick();
    check("final_wr_sb", 32'(wr_exp.size()), 32'd0);
    check("final_rd_sb", 32'(rd_exp.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
